// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory arbiter.
// Owner encoding tracks which requester gets next cycle's RAM response.
package core_mem_pkg;

   localparam int CORE_DATA_W = 32;
   localparam int BE_W        = CORE_DATA_W / 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/core_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Data-first priority with a bounded-streak starvation guard for fetch.
module core_mem_arbiter
   import core_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = CORE_DATA_W,
   parameter int MAX_DSTREAK = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_en,
   output logic [DATA_W/8-1:0] m_we,
   output logic [ADDR_W-3:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W-1:0]   m_rdata
);

   localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

   owner_e        owner_q;
   logic          st_q;
   logic [SW-1:0] dstreak_q;
   logic          pick_d;
   logic          pick_i;

   // With MAX_DSTREAK==0 the streak is always saturated, so fetch always wins.
   always_comb begin
      pick_d = 1'b0;
      pick_i = 1'b0;
      if (resetn) begin
         if (d_req && !(i_req && dstreak_q == SMAX))
            pick_d = 1'b1;
         else if (i_req)
            pick_i = 1'b1;
      end
   end

   always_comb begin
      i_gnt   = pick_i;
      d_gnt   = pick_d;
      m_en    = pick_i | pick_d;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      unique case (1'b1)
         pick_d: begin
            m_we    = d_we ? d_be : '0;
            m_addr  = d_addr[ADDR_W-1:2];
            m_wdata = d_wdata;
         end
         pick_i: begin
            m_addr  = i_addr[ADDR_W-1:2];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         owner_q   <= OWN_NONE;
         st_q      <= 1'b0;
         dstreak_q <= '0;
      end else begin
         if (pick_d)
            owner_q <= OWN_D;
         else if (pick_i)
            owner_q <= OWN_I;
         else
            owner_q <= OWN_NONE;
         st_q <= pick_d & d_we;
         if (pick_i || !i_req)
            dstreak_q <= '0;
         else if (pick_d && dstreak_q != SMAX)
            dstreak_q <= dstreak_q + SW'(1);
      end
   end

   // Responses are gated by reset so an in-flight access is dropped.
   always_comb begin
      i_rvalid = resetn && (owner_q == OWN_I);
      d_rvalid = resetn && (owner_q == OWN_D);
      i_rdata  = i_rvalid ? m_rdata : '0;
      d_rdata  = (d_rvalid && !st_q) ? m_rdata : '0;
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: behavioural RAM, shadow memory model,
// per-port response queues checked by an independent monitor.
module tb_core_mem_arbiter;
   import core_mem_pkg::*;

   logic            clk = 1'b0;
   logic            resetn;
   logic            i_req;
   logic [31:0]     i_addr;
   logic            i_gnt;
   logic            i_rvalid;
   logic [31:0]     i_rdata;
   logic            d_req;
   logic            d_we;
   logic [BE_W-1:0] d_be;
   logic [31:0]     d_addr;
   logic [31:0]     d_wdata;
   logic            d_gnt;
   logic            d_rvalid;
   logic [31:0]     d_rdata;
   logic            m_en;
   logic [BE_W-1:0] m_we;
   logic [29:0]     m_addr;
   logic [31:0]     m_wdata;
   logic [31:0]     m_rdata;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] mem    [256];
   logic [31:0] shadow [256];
   logic [31:0] iq [$];
   logic [31:0] dq [$];

   always #5 clk = ~clk;

   core_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)
   ) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   // Behavioural single-port RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (m_en) begin
         for (int b = 0; b < BE_W; b++)
            if (m_we[b])
               mem[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
         if (m_we == '0)
            m_rdata <= mem[m_addr[7:0]];
      end
   end

   a_i_hold: assert property (@(posedge clk) disable iff (!resetn)
      i_req && !i_gnt |=> i_req && $stable(i_addr));
   a_d_hold: assert property (@(posedge clk) disable iff (!resetn)
      d_req && !d_gnt |=> d_req && $stable(d_addr) && $stable(d_we));

   // Monitor: pops one expected word per response pulse.
   always @(negedge clk) begin
      if (i_rvalid) begin
         nvec++;
         if (iq.size() == 0) begin
            nerr++;
            $display("FAIL i_resp: unexpected i_rvalid, i_rdata=%h", i_rdata);
         end else begin
            logic [31:0] e;
            e = iq.pop_front();
            if (i_rdata !== e) begin
               nerr++;
               $display("FAIL i_resp: got %h expected %h", i_rdata, e);
            end
         end
      end
      if (d_rvalid) begin
         nvec++;
         if (dq.size() == 0) begin
            nerr++;
            $display("FAIL d_resp: unexpected d_rvalid, d_rdata=%h", d_rdata);
         end else begin
            logic [31:0] e;
            e = dq.pop_front();
            if (d_rdata !== e) begin
               nerr++;
               $display("FAIL d_resp: got %h expected %h", d_rdata, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Sample grants mid-cycle and queue the expected response.
   task automatic at_neg(input logic ei, input logic ed);
      @(negedge clk);
      nvec++;
      if (i_gnt !== ei || d_gnt !== ed) begin
         nerr++;
         $display("FAIL gnt: got i=%b d=%b expected i=%b d=%b",
                  i_gnt, d_gnt, ei, ed);
      end
      if (i_gnt)
         iq.push_back(shadow[i_addr[9:2]]);
      if (d_gnt) begin
         if (d_we) begin
            for (int b = 0; b < BE_W; b++)
               if (d_be[b])
                  shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
            dq.push_back('0);
         end else begin
            dq.push_back(shadow[d_addr[9:2]]);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic ei, input logic ed);
      at_neg(ei, ed);
      adv();
   endtask

   task automatic load(input logic [31:0] a);
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_be   = '0;
      d_addr = a;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) begin
         mem[k]    = 32'h1234_0000 + 32'(k) * 32'h11;
         shadow[k] = 32'h1234_0000 + 32'(k) * 32'h11;
      end
      m_rdata = '0;
      resetn  = 1'b0;
      i_req   = 1'b1;
      i_addr  = 32'h0;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_be    = '0;
      d_addr  = 32'h4;
      d_wdata = '0;

      // Reset: grants and all outputs held low even with requests present.
      @(negedge clk);
      chk("rst_i_gnt", {31'b0, i_gnt}, 32'h0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("rst_m_en", {31'b0, m_en}, 32'h0);
      chk("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
      chk("rst_rdata", i_rdata | d_rdata, 32'h0);
      adv();
      i_req = 1'b0;
      d_req = 1'b0;
      adv();
      resetn = 1'b1;

      // 1: fetch only.
      i_req  = 1'b1;
      i_addr = 32'h10;
      at_neg(1'b1, 1'b0);
      chk("t1_m_addr", {2'b0, m_addr}, 32'h4);
      chk("t1_m_we", {28'b0, m_we}, 32'h0);
      adv();
      i_req = 1'b0;
      at_neg(1'b0, 1'b0);
      chk("t1_rvalid", {31'b0, i_rvalid}, 32'h1);
      chk("t1_rdata", i_rdata, 32'h1234_0044);
      adv();

      // 2: partial store, then load back.
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_be    = 4'b0011;
      d_addr  = 32'h20;
      d_wdata = 32'hAABB_CCDD;
      at_neg(1'b0, 1'b1);
      chk("t2_m_we", {28'b0, m_we}, 32'h3);
      chk("t2_m_addr", {2'b0, m_addr}, 32'h8);
      chk("t2_m_wdata", m_wdata, 32'hAABB_CCDD);
      adv();
      load(32'h20);
      at_neg(1'b0, 1'b1);
      chk("t2_st_ack", {31'b0, d_rvalid}, 32'h1);
      chk("t2_st_rdata", d_rdata, 32'h0);
      adv();
      d_req = 1'b0;
      at_neg(1'b0, 1'b0);
      chk("t2_ld_rdata", d_rdata, 32'h1234_CCDD);
      adv();

      // 3: both held -> D,D,D,D,I repeating.
      i_req  = 1'b1;
      i_addr = 32'h40;
      load(32'h80);
      for (int k = 0; k < 15; k++)
         cyc(k % 5 == 4, k % 5 != 4);
      i_req = 1'b0;
      cyc(1'b0, 1'b1);
      d_req = 1'b0;
      cyc(1'b0, 1'b0);

      // 4: alternate fetch/load every cycle.
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            d_req  = 1'b0;
            i_req  = 1'b1;
            i_addr = 32'h100 + 32'(k) * 8;
         end else begin
            i_req = 1'b0;
            load(32'h200 + 32'(k) * 8);
         end
         at_neg(k % 2 == 0, k % 2 == 1);
         chk("t4_m_en", {31'b0, m_en}, 32'h1);
         adv();
      end
      i_req = 1'b0;
      d_req = 1'b0;
      cyc(1'b0, 1'b0);

      // 5: reset right after a load grant drops its response.
      load(32'h44);
      cyc(1'b0, 1'b1);
      d_req  = 1'b0;
      resetn = 1'b0;
      at_neg(1'b0, 1'b0);
      chk("t5_d_rvalid", {31'b0, d_rvalid}, 32'h0);
      chk("t5_d_rdata", d_rdata, 32'h0);
      chk("t5_m_en", {31'b0, m_en}, 32'h0);
      dq.delete();
      iq.delete();
      adv();
      resetn = 1'b1;
      load(32'h48);
      at_neg(1'b0, 1'b1);
      chk("t5_m_addr", {2'b0, m_addr}, 32'h12);
      adv();
      d_req = 1'b0;
      at_neg(1'b0, 1'b0);
      chk("t5_rdata", d_rdata, 32'h1234_0132);
      adv();

      // 6: fetch alone keeps the streak at 0; data wins first.
      i_req  = 1'b1;
      i_addr = 32'h30;
      for (int k = 0; k < 3; k++)
         cyc(1'b1, 1'b0);
      load(32'h34);
      for (int k = 0; k < 5; k++)
         cyc(k == 4, k != 4);
      i_req = 1'b0;
      cyc(1'b0, 1'b1);
      d_req = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);

      chk("end_iq_empty", 32'(iq.size()), 32'h0);
      chk("end_dq_empty", 32'(dq.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
